// File: rtl/alu16_scheduler.sv
// alu16_scheduler: round-robin arbiter that time-shares one alu16 among NREQ requesters.
// Define ALU16_SCHED_COUNT_CHECK_EN to enable the sticky alu_count mismatch flag on err.
module alu16_scheduler #(
  parameter int         NREQ       = 4,
  parameter int         IDW        = 2,
  parameter int         ALU_CYCLES = 18,
  parameter logic [3:0] EXP_COUNT  = 4'hF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [16*NREQ-1:0]  req_a,
  input  logic [16*NREQ-1:0]  req_b,
  input  logic [3*NREQ-1:0]   req_op,
  output logic [NREQ-1:0]     gnt,
  output logic                busy,
  output logic                res_valid,
  output logic [IDW-1:0]      res_id,
  output logic [16:0]         res_data,
  output logic                alu_on,
  output logic [15:0]         alu_ina,
  output logic [15:0]         alu_inb,
  output logic [2:0]          alu_op,
  input  logic [16:0]         alu_out,
  input  logic [3:0]          alu_count,
  output logic                err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_BUSY   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [7:0]      r_timer;

  logic [IDW-1:0]  w_win;
  logic [IDW-1:0]  w_sel;
  logic [NREQ-1:0] w_win_oh;
  logic            w_capture;
  int              w_idx;

  // Round-robin pick: scan from the farthest slot back so the nearest one after r_ptr wins.
  always_comb begin
    w_win = '0;
    w_sel = '0;
    w_idx = 0;
    for (int j = NREQ; j >= 1; j--) begin
      w_idx = (int'(r_ptr) + j) % NREQ;
      w_sel = IDW'(w_idx);
      if (req[w_sel]) begin
        w_win = w_sel;
      end else begin
        w_win = w_win;
      end
    end
  end

  assign w_win_oh  = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
  assign w_capture = (r_state == S_BUSY) && (r_timer == 8'd0);

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= IDW'(NREQ - 1);
      r_id      <= '0;
      r_timer   <= 8'd0;
      gnt       <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= 17'd0;
      alu_on    <= 1'b0;
      alu_ina   <= 16'd0;
      alu_inb   <= 16'd0;
      alu_op    <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            gnt     <= w_win_oh;
            alu_on  <= 1'b1;
            busy    <= 1'b1;
            alu_ina <= req_a[16*int'(w_win) +: 16];
            alu_inb <= req_b[16*int'(w_win) +: 16];
            alu_op  <= req_op[3*int'(w_win) +: 3];
            r_id    <= w_win;
            r_ptr   <= w_win;
            r_state <= S_LAUNCH;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LAUNCH: begin
          gnt     <= '0;
          alu_on  <= 1'b0;
          r_timer <= 8'(ALU_CYCLES - 1);
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          if (r_timer == 8'd0) begin
            res_data  <= alu_out;
            res_id    <= r_id;
            res_valid <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_timer <= r_timer - 8'd1;
          end
        end
        S_DONE: begin
          res_valid <= 1'b0;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          gnt       <= '0;
          alu_on    <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ALU16_SCHED_COUNT_CHECK_EN
  // Sticky flag: alu16 progress counter disagreed with the expected value at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (w_capture && (alu_count != EXP_COUNT)) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end
`else
  logic w_unused_count;
  assign w_unused_count = (^alu_count) ^ w_capture;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu16_scheduler.sv
// Randomized + directed bench for alu16_scheduler, checked against a cycle-level
// transaction model (round-robin pick, fixed latency, sticky count error).
module tb_alu16_scheduler;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int ALUC = 18;
`ifdef ALU16_SCHED_COUNT_CHECK_EN
  localparam bit CNT_CHK = 1'b1;
`else
  localparam bit CNT_CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [16*NREQ-1:0] req_a, req_b;
  logic [3*NREQ-1:0] req_op;
  logic [NREQ-1:0]   gnt;
  logic              busy, res_valid, alu_on, err;
  logic [IDW-1:0]    res_id;
  logic [16:0]       res_data, alu_out;
  logic [15:0]       alu_ina, alu_inb;
  logic [2:0]        alu_op;
  logic [3:0]        alu_count;

  int n_checks = 0;
  int n_errs   = 0;

  function automatic logic [16:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      3'd6:    return {a, 1'b0};
      default: return {2'b00, a[15:1]};
    endcase
  endfunction

  assign alu_out = alu_f(alu_ina, alu_inb, alu_op);

  alu16_scheduler #(.NREQ(NREQ), .IDW(IDW), .ALU_CYCLES(ALUC), .EXP_COUNT(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
    .alu_on(alu_on), .alu_ina(alu_ina), .alu_inb(alu_inb), .alu_op(alu_op),
    .alu_out(alu_out), .alu_count(alu_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  int          cyc = 0;
  int          m_busy = 0;
  int          m_k = 0;
  int          m_last = NREQ - 1;
  int          m_id = 0;
  int          m_w;
  logic [15:0] m_ea = 16'd0, m_eb = 16'd0;
  logic [2:0]  m_eo = 3'd0;
  logic [16:0] m_exp = 17'd0, m_rd = 17'd0;
  logic [1:0]  m_rid = 2'd0;
  logic        m_err = 1'b0;
  logic [3:0]  e_gnt;
  logic        e_on, e_busy, e_rv;

  // Observations for directed checks
  logic [3:0]  obs_g[$];
  int          obs_gc[$];
  int          obs_rcyc = 0;
  int          n_obs_res = 0;

  function automatic int pick(input logic [3:0] r, input int last);
    for (int j = 1; j <= NREQ; j++) begin
      if (r[(last + j) % NREQ]) return (last + j) % NREQ;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (gnt != 4'd0) begin
      obs_g.push_back(gnt);
      obs_gc.push_back(cyc);
    end
    if (res_valid) begin
      obs_rcyc = cyc;
      n_obs_res++;
    end
    if (!rst_n) begin
      m_busy = 0; m_k = 0; m_last = NREQ - 1; m_id = 0;
      m_ea = 16'd0; m_eb = 16'd0; m_eo = 3'd0; m_rd = 17'd0; m_rid = 2'd0; m_err = 1'b0;
      check("rst_outs", {gnt, busy, res_valid, res_id, res_data, alu_on, err}, 64'd0);
      check("rst_ops", {alu_ina, alu_inb, alu_op}, 64'd0);
    end else begin
      e_gnt = 4'd0; e_on = 1'b0; e_busy = 1'b0; e_rv = 1'b0;
      if (m_busy == 0) begin
        if (req != 4'd0) begin
          m_w = pick(req, m_last);
          m_last = m_w; m_id = m_w; m_k = 0; m_busy = 1;
          m_ea = req_a[16*m_w +: 16];
          m_eb = req_b[16*m_w +: 16];
          m_eo = req_op[3*m_w +: 3];
          m_exp = alu_f(m_ea, m_eb, m_eo);
          e_gnt = 4'b0001 << m_w; e_on = 1'b1; e_busy = 1'b1;
        end
      end else begin
        m_k++;
        e_busy = (m_k <= ALUC + 1);
        if (m_k == ALUC + 1) begin
          e_rv = 1'b1;
          m_rd = m_exp;
          m_rid = 2'(m_id);
          if (CNT_CHK && alu_count != 4'hF) m_err = 1'b1;
        end
        if (m_k == ALUC + 2) m_busy = 0;
      end
      check("gnt", gnt, e_gnt);
      check("alu_on", alu_on, e_on);
      check("busy", busy, e_busy);
      check("res_valid", res_valid, e_rv);
      check("res_data", res_data, m_rd);
      check("res_id", res_id, m_rid);
      check("err", err, m_err);
      check("operands", {alu_ina, alu_inb, alu_op}, {m_ea, m_eb, m_eo});
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag);
    int n0;
    int t;
    n0 = obs_g.size();
    t = 0;
    while (obs_g.size() == n0 && t < 60) begin
      @(negedge clk);
      #1;
      t++;
    end
    check({tag, "_granted"}, obs_g.size() > n0, 1'b1);
  endtask

  initial begin
    int nres0;
    rst_n = 1'b0; req = '0; req_a = '0; req_b = '0; req_op = '0; alu_count = 4'hF;
    // 1: reset with random request activity, then all requesters asserted
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      req = 4'($urandom);
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
    end
    rst_n = 1'b1;
    req = 4'b1111;
    // 3: grants rotate 0,1,2,3 at 21-clock spacing
    for (int i = 0; i < 4; i++) wait_grant("rr");
    check("rr_g0", obs_g[obs_g.size()-4], 4'b0001);
    check("rr_g1", obs_g[obs_g.size()-3], 4'b0010);
    check("rr_g2", obs_g[obs_g.size()-2], 4'b0100);
    check("rr_g3", obs_g[obs_g.size()-1], 4'b1000);
    for (int i = 1; i < 4; i++)
      check("rr_gap", obs_gc[obs_gc.size()-4+i] - obs_gc[obs_gc.size()-5+i], 21);
    req = 4'b0000;
    idle_cycles(25);

    // 2: single op from requester 2
    req_a[47:32] = 16'h7002; req_b[47:32] = 16'h8003; req_op[8:6] = 3'b000;
    req = 4'b0100;
    wait_grant("single");
    req = 4'b0000;
    check("single_gnt", obs_g[obs_g.size()-1], 4'b0100);
    idle_cycles(22);
    check("single_data", res_data, 17'h0F005);
    check("single_id", res_id, 2'd2);
    check("single_lat", obs_rcyc - obs_gc[obs_gc.size()-1], ALUC + 1);

    // 4: fairness after requester 0 was served
    req = 4'b0001;
    wait_grant("fair0");
    req = 4'b0000;
    idle_cycles(22);
    req = 4'b1001;
    wait_grant("fair1");
    wait_grant("fair2");
    check("fair_a", obs_g[obs_g.size()-2], 4'b1000);
    check("fair_b", obs_g[obs_g.size()-1], 4'b0001);
    req = 4'b0000;
    idle_cycles(25);

    // 5: reset while BUSY with timer=5 abandons the op
    req = 4'b0001;
    wait_grant("mid");
    req = 4'b0000;
    nres0 = n_obs_res;
    idle_cycles(13);
    rst_n = 1'b0;
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(30);
    check("mid_no_res", n_obs_res, nres0);
    check("mid_alu_on", alu_on, 1'b0);
    req = 4'b0010;
    wait_grant("mid_after");
    req = 4'b0000;
    check("mid_after_gnt", obs_g[obs_g.size()-1], 4'b0010);
    idle_cycles(22);
    check("mid_after_res", n_obs_res, nres0 + 1);

    // 6: count mismatch at capture
    alu_count = 4'h3;
    req = 4'b0001;
    wait_grant("cnt");
    req = 4'b0000;
    idle_cycles(22);
    check("cnt_err", err, CNT_CHK);
    alu_count = 4'hF;
    req = 4'b0010;
    wait_grant("cnt2");
    req = 4'b0000;
    idle_cycles(22);
    check("cnt_sticky", err, CNT_CHK);

    // Random traffic; the model checks every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
      req_op = 12'($urandom);
      alu_count = ($urandom_range(0, 15) == 0) ? 4'h3 : 4'hF;
    end
    req = 4'b0000;
    idle_cycles(25);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
